// File: rtl/udp_tx_arb_pkg.sv
// Shared types and constants for the UDP transmit arbiter.
package udp_tx_arb_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      GRANT   = 4'd1,
      HDR0    = 4'd2,
      HDR1    = 4'd3,
      CHECK   = 4'd4,
      SEND_H0 = 4'd5,
      SEND_H1 = 4'd6,
      PAYLOAD = 4'd7,
      DRAIN   = 4'd8
   } state_e;

   localparam int MAX_LEN_DEF = 1472;

   // The length header travels low byte first.
   localparam int HDR_LO_SHIFT = 0;
   localparam int HDR_HI_SHIFT = 8;

   function automatic logic [15:0] hdr_len(input logic [7:0] lo, input logic [7:0] hi);
      return (16'(lo) << HDR_LO_SHIFT) | (16'(hi) << HDR_HI_SHIFT);
   endfunction

   function automatic logic len_illegal(input logic [15:0] len, input logic [15:0] max_len);
      return (len == 16'd0) || (len > max_len);
   endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot winner and its index.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  pick_oh_o,
   output logic [IW-1:0] pick_idx_o
);

   int unsigned cand_s;
   logic        found_s;

   // Scan starts one past the previous owner so every source gets a turn.
   always_comb begin
      pick_oh_o  = '0;
      pick_idx_o = '0;
      found_s    = 1'b0;
      cand_s     = 0;
      for (int k = 1; k <= N; k++) begin
         cand_s = (int'(last_i) + k) % N;
         if (!found_s && req_i[IW'(cand_s)]) begin
            found_s                   = 1'b1;
            pick_oh_o[IW'(cand_s)]    = 1'b1;
            pick_idx_o                = IW'(cand_s);
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the single adaptive_udp transmit
// stream; validates the length header and repairs or drops malformed frames.
module udp_tx_arbiter
   import udp_tx_arb_pkg::*;
#(
   parameter int N_SRC   = 2,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int CNT_W   = 16
) (
   input  logic                 dri_clk,
   input  logic                 sys_rst,
   input  logic [N_SRC*8-1:0]   s_tdata,
   input  logic [N_SRC-1:0]     s_tvalid,
   input  logic [N_SRC-1:0]     s_tlast,
   output logic [N_SRC-1:0]     s_tready,
   output logic [7:0]           tx_data,
   output logic                 tx_tvalid,
   output logic                 tx_tlast,
   input  logic                 tx_req,
   output logic [N_SRC-1:0]     grant,
   output logic                 busy,
   output logic                 err_len,
   output logic                 err_short,
   output logic                 err_long,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   state_e             state_q, state_d;
   logic [N_SRC-1:0]   grant_q, grant_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [IW-1:0]      last_q, last_d;
   logic [7:0]         len_lo_q, len_lo_d;
   logic [7:0]         len_hi_q, len_hi_d;
   logic [15:0]        rem_q, rem_d;
   logic               err_len_q, err_len_d;
   logic               err_short_q, err_short_d;
   logic               err_long_q, err_long_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               drop_inc_s;
   logic [N_SRC-1:0]   pick_oh_s;
   logic [IW-1:0]      pick_idx_s;
   logic [7:0]         g_data_s;
   logic               g_valid_s;
   logic               g_last_s;

   rr_pick #(.N(N_SRC), .IW(IW)) u_rr_pick (
      .req_i      (s_tvalid),
      .last_i     (last_q),
      .pick_oh_o  (pick_oh_s),
      .pick_idx_o (pick_idx_s)
   );

   assign g_data_s  = s_tdata[{gidx_q, 3'b000} +: 8];
   assign g_valid_s = s_tvalid[gidx_q];
   assign g_last_s  = s_tlast[gidx_q];

   // Next-state, source ready and downstream stream for the current frame.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      last_d      = last_q;
      len_lo_d    = len_lo_q;
      len_hi_d    = len_hi_q;
      rem_d       = rem_q;
      err_len_d   = 1'b0;
      err_short_d = 1'b0;
      err_long_d  = 1'b0;
      drop_inc_s  = 1'b0;
      s_tready    = '0;
      tx_data     = 8'h00;
      tx_tvalid   = 1'b0;
      tx_tlast    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|s_tvalid) begin
               grant_d = pick_oh_s;
               gidx_d  = pick_idx_s;
               state_d = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: state_d = HDR0;
         HDR0: begin
            s_tready = grant_q;
            if (g_valid_s) begin
               len_lo_d = g_data_s;
               if (g_last_s) begin
                  err_len_d  = 1'b1;
                  drop_inc_s = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = HDR1;
               end
            end else begin
               state_d = HDR0;
            end
         end
         HDR1: begin
            s_tready = grant_q;
            if (g_valid_s) begin
               len_hi_d = g_data_s;
               if (g_last_s) begin
                  err_len_d  = 1'b1;
                  drop_inc_s = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = CHECK;
               end
            end else begin
               state_d = HDR1;
            end
         end
         CHECK: begin
            if (len_illegal(hdr_len(len_lo_q, len_hi_q), 16'(MAX_LEN))) begin
               err_len_d  = 1'b1;
               drop_inc_s = 1'b1;
               state_d    = DRAIN;
            end else begin
               rem_d   = hdr_len(len_lo_q, len_hi_q);
               state_d = SEND_H0;
            end
         end
         SEND_H0: begin
            tx_tvalid = 1'b1;
            tx_data   = len_lo_q;
            state_d   = tx_req ? SEND_H1 : SEND_H0;
         end
         SEND_H1: begin
            tx_tvalid = 1'b1;
            tx_data   = len_hi_q;
            state_d   = tx_req ? PAYLOAD : SEND_H1;
         end
         PAYLOAD: begin
            // Zero-latency pass-through; tlast is forced once the header count runs out.
            tx_data   = g_data_s;
            tx_tvalid = g_valid_s;
            tx_tlast  = g_valid_s & ((rem_q == 16'd1) | g_last_s);
            s_tready  = grant_q & {N_SRC{tx_req}};
            if (g_valid_s && tx_req) begin
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  if (g_last_s) begin
                     state_d = IDLE;
                  end else begin
                     err_long_d = 1'b1;
                     state_d    = DRAIN;
                  end
               end else if (g_last_s) begin
                  err_short_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  state_d = PAYLOAD;
               end
            end else begin
               state_d = PAYLOAD;
            end
         end
         DRAIN: begin
            s_tready = grant_q;
            state_d  = (g_valid_s && g_last_s) ? IDLE : DRAIN;
         end
         default: state_d = IDLE;
      endcase

      if (state_d == IDLE && state_q != IDLE) begin
         last_d  = gidx_q;
         grant_d = '0;
      end else begin
         last_d = last_d;
      end

      if (drop_inc_s && (drop_q != {CNT_W{1'b1}})) begin
         drop_d = drop_q + CNT_W'(1);
      end else begin
         drop_d = drop_q;
      end
   end

   // State and bookkeeping registers.
   always_ff @(posedge dri_clk) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         last_q      <= '0;
         len_lo_q    <= 8'h00;
         len_hi_q    <= 8'h00;
         rem_q       <= 16'd0;
         err_len_q   <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         last_q      <= last_d;
         len_lo_q    <= len_lo_d;
         len_hi_q    <= len_hi_d;
         rem_q       <= rem_d;
         err_len_q   <= err_len_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         drop_q      <= drop_d;
      end
   end

   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);
   assign err_len   = err_len_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;
   assign drop_cnt  = drop_q;

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit stream input of `adaptive_udp` (`tx_data`/`tx_tvalid`/`tx_tlast`, with `tx_req` as ready) between N AXI-Stream telegram sources, e.g. the PD and MD TRDP FIFOs.
- Each source frame is: `len[7:0]`, `len[15:8]`, then `len` payload bytes, with `tlast` on the final payload byte.
- The block does round-robin arbitration at frame boundaries.
- It buffers and validates the 2-byte length header, forces a correct `tx_tlast`, and drops or truncates malformed frames so the UDP core never sees a broken stream.

Parameters:
- `N_SRC`, 2, number of requesting sources (2..8).
- `MAX_LEN`, 1472, largest legal payload length in bytes.
- `CNT_W`, 16, width of the drop counter.

Ports:
- `dri_clk` in 1: single clock, the same domain as `adaptive_udp` `dri_clk`.
- `sys_rst` in 1: synchronous, active-high reset.
- `s_tdata` in N_SRC*8: source data; source i occupies bits [8i+7:8i].
- `s_tvalid` in N_SRC: per-source valid.
- `s_tlast` in N_SRC: per-source last.
- `s_tready` out N_SRC: per-source ready.
- `tx_data` out 8: to `adaptive_udp`.
- `tx_tvalid` out 1: to `adaptive_udp`.
- `tx_tlast` out 1: to `adaptive_udp`.
- `tx_req` in 1: ready from `adaptive_udp`.
- `grant` out N_SRC: one-hot owner of the current frame, 0 when idle.
- `busy` out 1: high whenever the state is not IDLE.
- `err_len` out 1: 1-cycle pulse on an illegal header.
- `err_short` out 1: 1-cycle pulse when source `tlast` arrives before `len` bytes.
- `err_long` out 1: 1-cycle pulse when the source overruns `len`.
- `drop_cnt` out CNT_W: count of dropped frames, saturating.

Behaviour:

Reset
- Synchronous active-high `sys_rst` forces state IDLE and sets the round-robin pointer to 0.
- It sets `grant`, `s_tready`, `tx_tvalid`, `tx_tlast`, the error pulses and `drop_cnt` to 0, and `tx_data` to 0x00.
- Reset mid-frame abandons the frame; no tail is emitted.

Arbitration (IDLE)
- Scan `s_tvalid` starting from `(last_grant+1) mod N_SRC`; the first asserted source wins.
- `grant` registers the winner on the next cycle, and the state moves to HDR0.
- No request means the block stays in IDLE.
- `grant` holds until the frame completes, the frame is dropped, or reset.

Hand-shaking
- A handshake is `valid & ready` sampled on the rising edge.
- Only the granted source ever sees `s_tready=1`.

States
- HDR0: `s_tready[g]=1`. On handshake, capture `len_lo` and go to HDR1.
- HDR1: capture `len_hi` and go to CHECK.
- Header `tlast`: if `s_tlast` is set on either header byte, pulse `err_len`, increment `drop_cnt`, and go to IDLE.
- CHECK (one cycle, no handshakes): let `L = {len_hi, len_lo}`.
  - If `L==0` or `L>MAX_LEN`, pulse `err_len`, increment `drop_cnt`, and go to DRAIN.
  - Otherwise load `rem=L` and go to SEND_H0.
- SEND_H0: `tx_tvalid=1`, `tx_data=len_lo`. On `tx_req`, go to SEND_H1.
- SEND_H1: `tx_tvalid=1`, `tx_data=len_hi`. On `tx_req`, go to PAYLOAD.
- PAYLOAD: combinational pass-through with zero latency.
  - `tx_data=s_tdata[g]`, `tx_tvalid=s_tvalid[g]`, `s_tready[g]=tx_req`.
  - `tx_tlast = s_tvalid[g] & (rem==1 | s_tlast[g])`.
  - Each handshake decrements `rem`.
  - Handshake with `rem==1` and `s_tlast=1`: normal end, go to IDLE.
  - Handshake with `rem==1` and `s_tlast=0`: pulse `err_long`, go to DRAIN.
  - Handshake with `rem>1` and `s_tlast=1`: pulse `err_short`, go to IDLE. The frame is truncated downstream and is not counted as dropped.
- DRAIN: `s_tready[g]=1`, `tx_tvalid=0`. Discard bytes until an `s_tvalid & s_tlast` handshake, then go to IDLE.
- On every return to IDLE: `last_grant` takes g and `grant` clears.

Outputs outside the states above
- `tx_tvalid=0`, `tx_tlast=0`, `tx_data=0x00`.

Counters and timing
- `drop_cnt` saturates at all-ones.
- Minimum frame overhead is 5 cycles: IDLE, HDR0, HDR1, CHECK, plus the grant-register cycle. Back-to-back frames from different sources are legal.
- Because of the registered grant, a request from a different source in the same cycle as a frame end is served after 1 IDLE cycle.

Decomposition:
- Package `udp_tx_arb_pkg`: state enum (IDLE, GRANT, HDR0, HDR1, CHECK, SEND_H0, SEND_H1, PAYLOAD, DRAIN), the `MAX_LEN` default, and the header byte-order constants.
- One sub-module, `rr_pick`: a combinational round-robin one-hot picker taking the request vector and the last-grant index, returning a one-hot result and an index.

Test Plan:
- Single frame, N_SRC=2: src0 sends 0x41,0x00 followed by 65 bytes, with `tx_req` held high. Expected: `tx` carries 67 bytes, `tx_tlast` only on byte 67, `grant=01`, no error pulses.
- Fairness: src0 and src1 both continuously present 8-byte frames. Expected: output frames alternate 0,1,0,1, with 1 IDLE cycle between frames.
- Backpressure: `tx_req` toggles pseudo-randomly during a 65-byte frame. Expected: bytes are identical and in order, no byte is lost or duplicated, and `s_tready` equals `tx_req` during PAYLOAD.
- Illegal header: `L=0x0000`, then `L=0x05C1` (1473) followed by 3 bytes ending in `tlast`. Expected: `err_len` pulses twice, `drop_cnt=2`, `tx_tvalid` never asserts, and both frames are drained.
- Length mismatch:
  - Short: `L=10` with `tlast` on byte 6. Expected: `tx_tlast` on byte 6 and `err_short`.
  - Long: `L=4` with 7 bytes. Expected: `tx_tlast` forced on byte 4, `err_long`, 3 bytes drained, and the next frame unaffected.
- Reset mid-frame: assert `sys_rst` for 1 cycle while in PAYLOAD with `rem=20`. Expected: all outputs are 0 on the next cycle and the state is IDLE. The next src1 frame completes cleanly with a fresh header.
